// File: rtl/seq_div32_pkg.sv
// Shared constants for the sequential divider: widths, FSM encoding, latency.
// SIGNED_DIV_EN selects the signed build's latency constant.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int DIV_LAT_UNSIGNED = 33;
  localparam int DIV_LAT_SIGNED   = 34;

`ifdef SIGNED_DIV_EN
  localparam int DIV_LATENCY = DIV_LAT_SIGNED;
`else
  localparam int DIV_LATENCY = DIV_LAT_UNSIGNED;
`endif

endpackage

// File: rtl/seq_div32_if.sv
// Operand/result bus of the divider, shared with the array multiplier.
// SIGNED_DIV_EN adds the sgn operand-mode line.
interface seq_div32_if;
  import div_pkg::*;

  logic                 start;
  logic [DIV_WIDTH-1:0] dvd;
  logic [DIV_WIDTH-1:0] dvs;
`ifdef SIGNED_DIV_EN
  logic                 sgn;
`endif
  logic                 busy;
  logic                 done;
  logic [DIV_WIDTH-1:0] q;
  logic [DIV_WIDTH-1:0] r;
  logic                 divZero;

  modport master (
    output start, dvd, dvs,
`ifdef SIGNED_DIV_EN
    output sgn,
`endif
    input  busy, done, q, r, divZero
  );

  modport slave (
    input  start, dvd, dvs,
`ifdef SIGNED_DIV_EN
    input  sgn,
`endif
    output busy, done, q, r, divZero
  );

endinterface

// File: rtl/seq_div32_prefix_sub33.sv
// 33-bit Kogge-Stone prefix adder; the divider drives it as a subtractor
// (y inverted, cIn = 1, borrow = ~cOut).
module prefix_sub33 (
  input  logic [32:0] x,
  input  logic [32:0] y,
  input  logic        cIn,
  output logic [32:0] s,
  output logic        cOut
);

  logic [32:0] w_p0;
  logic [32:0] w_g;
  logic [32:0] w_p;
  logic [32:0] w_g_nx;
  logic [32:0] w_p_nx;

  assign w_p0 = x ^ y;

  // Log-depth group generate/propagate; carry-in folds into bit 0's generate.
  always_comb begin
    w_g    = (x & y) | {32'b0, w_p0[0] & cIn};
    w_p    = w_p0;
    w_g_nx = w_g;
    w_p_nx = w_p;
    for (int lv = 0; lv < 6; lv++) begin
      for (int i = 0; i < 33; i++) begin
        if (i >= (1 << lv)) begin
          w_g_nx[i] = w_g[i] | (w_p[i] & w_g[i - (1 << lv)]);
          w_p_nx[i] = w_p[i] & w_p[i - (1 << lv)];
        end else begin
          w_g_nx[i] = w_g[i];
          w_p_nx[i] = w_p[i];
        end
      end
      w_g = w_g_nx;
      w_p = w_p_nx;
    end
  end

  assign s    = w_p0 ^ {w_g[31:0], cIn};
  assign cOut = w_g[32];

endmodule

// File: rtl/seq_div32.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Define SIGNED_DIV_EN for two's-complement support (sgn port, FIX state).
module seq_div32 import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic         clk,
  input logic         rst,
  seq_div32_if.slave  bus
);

  logic [1:0]           r_state;
  logic [DIV_CNT_W-1:0] r_cnt;
  logic [WIDTH:0]       r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_dvs;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dz;

  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_sub_x;
  logic [WIDTH:0]       w_sub_y;
  logic [WIDTH:0]       w_sub_s;
  logic                 w_sub_cout;
  logic [WIDTH-1:0]     w_dvd_ld;
  logic [WIDTH-1:0]     w_dvs_ld;
  logic                 w_unused_bits;

`ifdef SIGNED_DIV_EN
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [WIDTH:0]       w_neg_y;
  logic [WIDTH:0]       w_neg_s;
  logic                 w_neg_cout;
  logic                 w_dvd_neg;
  logic                 w_dvs_neg;
`endif

  // Operand select: trial subtraction in ITER, 0 - value negations at load and in FIX.
  always_comb begin
    w_rem_sh = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    w_sub_x  = w_rem_sh;
    w_sub_y  = ~{1'b0, r_dvs};
`ifdef SIGNED_DIV_EN
    w_neg_y  = ~{1'b0, bus.dvs};
    case (r_state)
      ST_IDLE: begin
        w_sub_x = {(WIDTH+1){1'b0}};
        w_sub_y = ~{1'b0, bus.dvd};
      end
      ST_FIX: begin
        w_sub_x = {(WIDTH+1){1'b0}};
        w_sub_y = ~{1'b0, r_quo};
        w_neg_y = ~{1'b0, r_rem[WIDTH-1:0]};
      end
      default: begin
        w_neg_y = ~{1'b0, bus.dvs};
      end
    endcase
`endif
  end

  prefix_sub33 u_sub (
    .x(w_sub_x), .y(w_sub_y), .cIn(1'b1), .s(w_sub_s), .cOut(w_sub_cout)
  );

`ifdef SIGNED_DIV_EN
  prefix_sub33 u_neg (
    .x({(WIDTH+1){1'b0}}), .y(w_neg_y), .cIn(1'b1), .s(w_neg_s), .cOut(w_neg_cout)
  );

  // A zero divisor keeps the raw dividend so the natural result r = dividend survives.
  assign w_dvd_neg     = bus.sgn & bus.dvd[WIDTH-1] & (bus.dvs != {WIDTH{1'b0}});
  assign w_dvs_neg     = bus.sgn & bus.dvs[WIDTH-1];
  assign w_dvd_ld      = w_dvd_neg ? w_sub_s[WIDTH-1:0] : bus.dvd;
  assign w_dvs_ld      = w_dvs_neg ? w_neg_s[WIDTH-1:0] : bus.dvs;
  assign w_unused_bits = ^{r_rem[WIDTH], w_neg_s[WIDTH], w_neg_cout};
`else
  assign w_dvd_ld      = bus.dvd;
  assign w_dvs_ld      = bus.dvs;
  assign w_unused_bits = r_rem[WIDTH];
`endif

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= {DIV_CNT_W{1'b0}};
      r_rem   <= {(WIDTH+1){1'b0}};
      r_quo   <= {WIDTH{1'b0}};
      r_dvs   <= {WIDTH{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
`ifdef SIGNED_DIV_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_quo   <= w_dvd_ld;
            r_dvs   <= w_dvs_ld;
            r_rem   <= {(WIDTH+1){1'b0}};
            r_cnt   <= 5'd31;
            r_busy  <= 1'b1;
            r_dz    <= (bus.dvs == {WIDTH{1'b0}});
            r_state <= ST_ITER;
`ifdef SIGNED_DIV_EN
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ITER: begin
          r_rem <= w_sub_cout ? w_sub_s : w_rem_sh;
          r_quo <= {r_quo[WIDTH-2:0], w_sub_cout};
          if (r_cnt == {DIV_CNT_W{1'b0}}) begin
`ifdef SIGNED_DIV_EN
            r_state <= ST_FIX;
`else
            r_state <= ST_DONE;
`endif
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
`ifdef SIGNED_DIV_EN
        ST_FIX: begin
          if (r_neg_q) begin
            r_quo <= w_sub_s[WIDTH-1:0];
          end
          if (r_neg_r) begin
            r_rem <= {1'b0, w_neg_s[WIDTH-1:0]};
          end
          r_state <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (!r_done) begin
            r_done <= 1'b1;
          end else begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.q       = r_quo;
  assign bus.r       = r_rem[WIDTH-1:0];
  assign bus.divZero = r_dz;

endmodule
